// File: rtl/gb_io_pkg.sv
// Shared I/O register map and encodings for the Game Boy peripheral slice.
package gb_io_pkg;

  localparam logic [15:0] ADDR_DIV  = 16'hff04;
  localparam logic [15:0] ADDR_TIMA = 16'hff05;
  localparam logic [15:0] ADDR_TMA  = 16'hff06;
  localparam logic [15:0] ADDR_TAC  = 16'hff07;
  localparam logic [15:0] ADDR_IF   = 16'hff0f;

  // TAC[1:0] clock-select codes, named by the divider they give.
  localparam logic [1:0] TAC_1024 = 2'b00;
  localparam logic [1:0] TAC_16   = 2'b01;
  localparam logic [1:0] TAC_64   = 2'b10;
  localparam logic [1:0] TAC_256  = 2'b11;

  localparam int IRQ_TIMER = 2;

endpackage

// File: rtl/gb_timer_tick.sv
// TIMA tick source: selects a counter tap by TAC, gates it with the enable
// bit and strobes on its falling edge against the previous cycle's value.
module gb_timer_tick
  import gb_io_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] taps,
  input  logic [2:0] tac,
  output logic       tick
);

  logic sel;
  logic tsig;
  logic tsig_q;

  // taps = {counter[9], counter[7], counter[5], counter[3]}
  always_comb begin
    sel = 1'b0;
    case (tac[1:0])
      TAC_1024: sel = taps[3];
      TAC_16:   sel = taps[0];
      TAC_64:   sel = taps[1];
      TAC_256:  sel = taps[2];
      default:  sel = 1'b0;
    endcase
    tsig = sel & tac[2];
  end

  always_ff @(posedge clock) begin
    if (reset) tsig_q <= 1'b0;
    else       tsig_q <= tsig;
  end

  // Any 1->0 of the gated tap counts, including ones caused by DIV/TAC writes.
  assign tick = tsig_q & ~tsig;

endmodule

// File: rtl/gb_timer.sv
// DIV/TIMA/TMA/TAC timer: system counter, TIMA with delayed TMA reload and
// interrupt, and a two-stage registered CPU read port.
module gb_timer
  import gb_io_pkg::*;
#(
  parameter logic [15:0] BASE  = 16'hff04,
  parameter int          CNT_W = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        load,
  input  logic        store,
  output logic [7:0]  rdata,
  output logic        hit,
  output logic        irq
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] counter;
  logic [7:0]       tima;
  logic [7:0]       tma;
  logic [2:0]       tac;
  logic             reload_pend;
  logic             tick;

  logic [15:0] offset;
  logic        in_range;
  logic [1:0]  reg_idx;
  logic        wr_div;
  logic        wr_tima;
  logic        wr_tma;
  logic        wr_tac;
  logic [7:0]  rd_val;

  logic [7:0]  rd_val_q;
  logic        rd_hit_q;
  logic        rd_vld_q;

  // Addresses below BASE wrap to large offsets, so one compare covers the window.
  assign offset   = addr - BASE;
  assign in_range = offset < 16'd4;
  assign reg_idx  = offset[1:0];

  assign wr_div  = store && in_range && reg_idx == 2'd0;
  assign wr_tima = store && in_range && reg_idx == 2'd1;
  assign wr_tma  = store && in_range && reg_idx == 2'd2;
  assign wr_tac  = store && in_range && reg_idx == 2'd3;

  gb_timer_tick u_tick (
    .clock (clock),
    .reset (reset),
    .taps  ({counter[9], counter[7], counter[5], counter[3]}),
    .tac   (tac),
    .tick  (tick)
  );

  always_comb begin
    rd_val = 8'h00;
    if (in_range) begin
      case (reg_idx)
        2'd0:    rd_val = counter[CNT_W-1 -: 8];
        2'd1:    rd_val = tima;
        2'd2:    rd_val = tma;
        default: rd_val = {5'b11111, tac};
      endcase
    end
  end

  // irq doubles as the "reload cycle" marker for write-priority decisions.
  always_ff @(posedge clock) begin
    if (reset) begin
      counter     <= '0;
      tima        <= 8'h00;
      tma         <= 8'h00;
      tac         <= 3'b000;
      reload_pend <= 1'b0;
      irq         <= 1'b0;
    end else begin
      counter <= wr_div ? '0 : counter + CNT_ONE;
      irq     <= 1'b0;
      if (wr_tma) tma <= wdata;
      if (wr_tac) tac <= wdata[2:0];

      if (reload_pend) begin
        reload_pend <= 1'b0;
        if (wr_tima) begin
          tima <= wdata;
        end else begin
          tima <= tma;
          irq  <= 1'b1;
        end
      end else if (irq && wr_tma) begin
        tima <= wdata;
      end else if (wr_tima && !irq) begin
        tima <= wdata;
      end else if (tick) begin
        tima <= tima + 8'd1;
        if (tima == 8'hff) reload_pend <= 1'b1;
      end
    end
  end

  // Stage 1 captures pre-write register contents; stage 2 presents them.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_val_q <= 8'h00;
      rd_hit_q <= 1'b0;
      rd_vld_q <= 1'b0;
      rdata    <= 8'h00;
      hit      <= 1'b0;
    end else begin
      rd_vld_q <= load;
      if (load) begin
        rd_val_q <= rd_val;
        rd_hit_q <= in_range;
      end
      hit <= rd_vld_q & rd_hit_q;
      if (rd_vld_q) rdata <= rd_val_q;
    end
  end

endmodule
